// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Purpose  : Bundles the fetch, LSU and byte-wide RAM signals of mem_ctrl.
//            The slave modport is the controller's view; master is the
//            requester/RAM side.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;
  logic        rdy_in;
  logic        rollback_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_ok_out;
  logic [31:0] if_data_out;
  logic        lsu_en_in;
  logic [31:0] lsu_addr_in;
  logic [31:0] lsu_data_in;
  logic        lsu_rw_in;
  logic [2:0]  lsu_size_in;
  logic        lsu_ok_out;
  logic [31:0] lsu_data_out;
  logic [31:0] mem_a_out;
  logic [7:0]  mem_dout_out;
  logic        mem_wr_out;
  logic [7:0]  mem_din_in;
  logic        io_buffer_full_in;

  modport slave (
    input  rdy_in, rollback_in, if_req_in, if_addr_in,
           lsu_en_in, lsu_addr_in, lsu_data_in, lsu_rw_in, lsu_size_in,
           mem_din_in, io_buffer_full_in,
    output if_ok_out, if_data_out, lsu_ok_out, lsu_data_out,
           mem_a_out, mem_dout_out, mem_wr_out
  );

  modport master (
    output rdy_in, rollback_in, if_req_in, if_addr_in,
           lsu_en_in, lsu_addr_in, lsu_data_in, lsu_rw_in, lsu_size_in,
           mem_din_in, io_buffer_full_in,
    input  if_ok_out, if_data_out, lsu_ok_out, lsu_data_out,
           mem_a_out, mem_dout_out, mem_wr_out
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-serial memory controller arbitrating instruction fetch and
//            LSU accesses onto a single byte-wide RAM with one cycle read
//            latency. LSU requests win over fetch; one access in flight.
//            Optional feature: define IO_STALL_EN to hold writes to the
//            I/O window (addr[17:16] == 2'b11) while the UART buffer is full.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl (
  input  logic      clk_in,
  input  logic      rst_n_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Access sequencing
  state_e      state_q, state_d;
  logic        src_lsu_q, src_lsu_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;

  // One-entry LSU pending slot (size stored already normalised)
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_rw_q, pend_rw_d;
  logic [2:0]  pend_size_q, pend_size_d;

  // Registered outputs
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_ok_q, if_ok_d;
  logic [31:0] if_data_q, if_data_d;
  logic        lsu_ok_q, lsu_ok_d;
  logic [31:0] lsu_data_q, lsu_data_d;

  // Which source of the LSU request was consumed this edge
  logic        take_pend;
  logic        take_in;

  logic        w_lsu_avail;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_data;
  logic        w_req_rw;
  logic [2:0]  w_req_size;
  logic        w_io_block;
  logic [31:0] w_rd_word;
  logic [7:0]  w_wbyte;

  // Sizes other than 1 and 2 behave as a full word
  function automatic logic [2:0] norm_size(input logic [2:0] s);
    case (s)
      3'd1:    norm_size = 3'd1;
      3'd2:    norm_size = 3'd2;
      default: norm_size = 3'd4;
    endcase
  endfunction

  // Present the oldest LSU request: the slot, else a pulse arriving now
  always_comb begin
    w_lsu_avail = pend_valid_q | bus.lsu_en_in;
    if (pend_valid_q) begin
      w_req_addr = pend_addr_q;
      w_req_data = pend_data_q;
      w_req_rw   = pend_rw_q;
      w_req_size = pend_size_q;
    end else begin
      w_req_addr = bus.lsu_addr_in;
      w_req_data = bus.lsu_data_in;
      w_req_rw   = bus.lsu_rw_in;
      w_req_size = norm_size(bus.lsu_size_in);
    end
  end

`ifdef IO_STALL_EN
  assign w_io_block = w_req_rw && (w_req_addr[17:16] == 2'b11) && bus.io_buffer_full_in;
`else
  logic w_unused_io_full;
  assign w_unused_io_full = bus.io_buffer_full_in;
  assign w_io_block       = 1'b0;
`endif

  // Byte (cnt_q - 2) returns on mem_din_in this cycle; merge it into the word.
  // Bytes above the access size are never merged and so stay zero.
  assign w_rd_word = rbuf_q | ({24'd0, bus.mem_din_in} << {cnt_q - 3'd2, 3'b000});
  assign w_wbyte   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

  // Access FSM: arbitration, address/data sequencing and completion pulses
  always_comb begin
    state_d    = state_q;
    src_lsu_d  = src_lsu_q;
    base_d     = base_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_ok_d    = if_ok_q;
    if_data_d  = if_data_q;
    lsu_ok_d   = lsu_ok_q;
    lsu_data_d = lsu_data_q;
    take_pend  = 1'b0;
    take_in    = 1'b0;

    if (bus.rdy_in) begin
      if_ok_d  = 1'b0;
      lsu_ok_d = 1'b0;
      case (state_q)
        IDLE: begin
          mem_wr_d = 1'b0;
          // A flush edge starts nothing; a held write starts on the next edge
          if (!bus.rollback_in) begin
            if (w_lsu_avail) begin
              // A blocked I/O write also holds off fetch to keep ordering
              if (!w_io_block) begin
                take_pend = pend_valid_q;
                take_in   = !pend_valid_q;
                src_lsu_d = 1'b1;
                base_d    = w_req_addr;
                size_d    = w_req_size;
                cnt_d     = 3'd1;
                mem_a_d   = w_req_addr;
                if (w_req_rw) begin
                  state_d    = WRITE;
                  wdata_d    = w_req_data;
                  mem_dout_d = w_req_data[7:0];
                  mem_wr_d   = 1'b1;
                end else begin
                  state_d = READ;
                  rbuf_d  = 32'd0;
                end
              end
            end else if (bus.if_req_in) begin
              state_d   = READ;
              src_lsu_d = 1'b0;
              base_d    = bus.if_addr_in;
              size_d    = 3'd4;
              cnt_d     = 3'd1;
              mem_a_d   = bus.if_addr_in;
              rbuf_d    = 32'd0;
            end
          end
        end

        READ: begin
          // cnt_q counts edges since acceptance: issue while cnt < N,
          // sample byte cnt-2 from cnt = 2, finish at cnt = N + 1
          if (cnt_q < size_q) begin
            mem_a_d = base_q + {29'd0, cnt_q};
          end
          if (cnt_q >= 3'd2) begin
            rbuf_d = w_rd_word;
          end
          if (bus.rollback_in) begin
            state_d = IDLE;
          end else if (cnt_q == size_q + 3'd1) begin
            state_d = IDLE;
            if (src_lsu_q) begin
              lsu_ok_d   = 1'b1;
              lsu_data_d = w_rd_word;
            end else begin
              if_ok_d   = 1'b1;
              if_data_d = w_rd_word;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        WRITE: begin
          // Writes are committed to memory, so a flush never cuts them short
          if (cnt_q < size_q) begin
            mem_a_d    = base_q + {29'd0, cnt_q};
            mem_dout_d = w_wbyte;
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end else begin
            mem_wr_d = 1'b0;
            lsu_ok_d = 1'b1;
            state_d  = IDLE;
          end
        end

        default: begin
          state_d  = IDLE;
          mem_wr_d = 1'b0;
        end
      endcase
    end
  end

  // Pending slot: captures every LSU pulse, even while the controller is frozen
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_rw_d    = pend_rw_q;
    pend_size_d  = pend_size_q;
    if (bus.rdy_in) begin
      if (bus.rollback_in && !pend_rw_q) begin
        pend_valid_d = 1'b0;
      end
      if (take_pend) begin
        pend_valid_d = 1'b0;
      end
      if (bus.lsu_en_in && !take_in && !(bus.rollback_in && !bus.lsu_rw_in)) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = bus.lsu_addr_in;
        pend_data_d  = bus.lsu_data_in;
        pend_rw_d    = bus.lsu_rw_in;
        pend_size_d  = norm_size(bus.lsu_size_in);
      end
    end else if (bus.lsu_en_in) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = bus.lsu_addr_in;
      pend_data_d  = bus.lsu_data_in;
      pend_rw_d    = bus.lsu_rw_in;
      pend_size_d  = norm_size(bus.lsu_size_in);
    end
  end

  // State and output registers; reset clears everything without a clock
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      src_lsu_q    <= 1'b0;
      base_q       <= 32'd0;
      size_q       <= 3'd0;
      cnt_q        <= 3'd0;
      wdata_q      <= 32'd0;
      rbuf_q       <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'd0;
      pend_data_q  <= 32'd0;
      pend_rw_q    <= 1'b0;
      pend_size_q  <= 3'd0;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      if_ok_q      <= 1'b0;
      if_data_q    <= 32'd0;
      lsu_ok_q     <= 1'b0;
      lsu_data_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      src_lsu_q    <= src_lsu_d;
      base_q       <= base_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_rw_q    <= pend_rw_d;
      pend_size_q  <= pend_size_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_ok_q      <= if_ok_d;
      if_data_q    <= if_data_d;
      lsu_ok_q     <= lsu_ok_d;
      lsu_data_q   <= lsu_data_d;
    end
  end

  assign bus.mem_a_out    = mem_a_q;
  assign bus.mem_dout_out = mem_dout_q;
  assign bus.mem_wr_out   = mem_wr_q;
  assign bus.if_ok_out    = if_ok_q;
  assign bus.if_data_out  = if_data_q;
  assign bus.lsu_ok_out   = lsu_ok_q;
  assign bus.lsu_data_out = lsu_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Scoreboard bench for mem_ctrl. A byte RAM model answers the
//            controller; a reference memory predicts read data, write
//            contents and the completion edge of every access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
    bit          chk_data;
  } exp_t;

  exp_t if_q[$];
  exp_t lsu_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  bit last_rdy = 1'b1;

`ifdef IO_STALL_EN
  int io_stall = 3;
`else
  int io_stall = 0;
`endif

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int size_bytes(input logic [2:0] s);
    return (s == 3'd1) ? 1 : (s == 3'd2) ? 2 : 4;
  endfunction

  // Edge counter and RAM: data addressed in one cycle is visible the next
  always @(posedge clk) begin
    ecnt     <= ecnt + 1;
    last_rdy <= bus.rdy_in;
    bus.mem_din_in <= ram_rd(bus.mem_a_out);
    if (bus.mem_wr_out) ram[bus.mem_a_out] = bus.mem_dout_out;
  end

  // Monitor: every new completion pulse pops and checks its expectation
  always @(negedge clk) begin
    if (rst_n && last_rdy) begin
      if (bus.lsu_ok_out) begin
        n_checks++;
        if (lsu_q.size() == 0) begin
          n_fail++;
          $display("FAIL lsu_ok_unexpected: got pulse at edge %0d, required none", ecnt);
        end else begin
          mon_e = lsu_q.pop_front();
          if (ecnt != mon_e.edge_no) begin
            n_fail++;
            $display("FAIL lsu_ok_edge: got %0d, required %0d", ecnt, mon_e.edge_no);
          end
          if (mon_e.chk_data) begin
            n_checks++;
            if (bus.lsu_data_out !== mon_e.data) begin
              n_fail++;
              $display("FAIL lsu_data: got %h, required %h", bus.lsu_data_out, mon_e.data);
            end
          end
        end
      end
      if (bus.if_ok_out) begin
        n_checks++;
        if (if_q.size() == 0) begin
          n_fail++;
          $display("FAIL if_ok_unexpected: got pulse at edge %0d, required none", ecnt);
        end else begin
          mon_e = if_q.pop_front();
          if (ecnt != mon_e.edge_no) begin
            n_fail++;
            $display("FAIL if_ok_edge: got %0d, required %0d", ecnt, mon_e.edge_no);
          end
          n_checks++;
          if (bus.if_data_out !== mon_e.data) begin
            n_fail++;
            $display("FAIL if_data: got %h, required %h", bus.if_data_out, mon_e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // LSU request: predicted completion = acceptance edge + N (write) or N+1 (read)
  task automatic lsu_op(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] size, input bit expect_ok, input int extra);
    exp_t e;
    int   n;
    n          = size_bytes(size);
    e.edge_no  = ecnt + 1 + extra + (rw ? n : n + 1);
    e.chk_data = !rw;
    e.data     = 32'd0;
    for (int j = 0; j < n; j++) begin
      if (rw) ref_mem[addr + 32'(j)] = data[8*j +: 8];
      else    e.data = e.data | (32'(ref_rd(addr + 32'(j))) << (8*j));
    end
    if (expect_ok) lsu_q.push_back(e);
    bus.lsu_en_in   = 1'b1;
    bus.lsu_addr_in = addr;
    bus.lsu_data_in = data;
    bus.lsu_rw_in   = rw;
    bus.lsu_size_in = size;
    @(posedge clk);
    #1;
    bus.lsu_en_in = 1'b0;
  endtask

  // Fetch request: a word read, held until its completion is seen
  task automatic if_op(input logic [31:0] addr, input int extra, input bit expect_ok);
    exp_t e;
    e.edge_no  = ecnt + 1 + extra + 5;
    e.chk_data = 1'b1;
    e.data     = 32'd0;
    for (int j = 0; j < 4; j++) e.data = e.data | (32'(ref_rd(addr + 32'(j))) << (8*j));
    if (expect_ok) if_q.push_back(e);
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = addr;
  endtask

  // Wait until every expected completion has been observed
  task automatic wait_idle();
    int  k;
    bit  done;
    done = 1'b0;
    for (k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      #1;
      if (bus.if_ok_out) bus.if_req_in = 1'b0;
      done = (if_q.size() == 0) && (lsu_q.size() == 0) && !bus.if_req_in;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got %0d if / %0d lsu outstanding, required 0", if_q.size(), lsu_q.size());
      if_q.delete();
      lsu_q.delete();
      bus.if_req_in = 1'b0;
    end
  endtask

  task automatic check_mem(input logic [31:0] addr, input int n);
    for (int j = 0; j <= n; j++)
      chk("mem_byte", {24'd0, ram_rd(addr + 32'(j))}, {24'd0, ref_rd(addr + 32'(j))});
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_if_ok"},    {31'd0, bus.if_ok_out},  32'd0);
    chk({tag, "_if_data"},  bus.if_data_out,         32'd0);
    chk({tag, "_lsu_ok"},   {31'd0, bus.lsu_ok_out}, 32'd0);
    chk({tag, "_lsu_data"}, bus.lsu_data_out,        32'd0);
    chk({tag, "_mem_a"},    bus.mem_a_out,           32'd0);
    chk({tag, "_mem_dout"}, {24'd0, bus.mem_dout_out}, 32'd0);
    chk({tag, "_mem_wr"},   {31'd0, bus.mem_wr_out}, 32'd0);
  endtask

  initial begin
    logic [2:0]  sizes [8] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd3, 3'd0, 3'd7, 3'd5};
    logic [31:0] addr;
    logic [2:0]  sz;
    int          kind;

    bus.rdy_in = 1'b1;
    bus.rollback_in = 1'b0;
    bus.if_req_in = 1'b0;
    bus.if_addr_in = 32'd0;
    bus.lsu_en_in = 1'b0;
    bus.lsu_addr_in = 32'd0;
    bus.lsu_data_in = 32'd0;
    bus.lsu_rw_in = 1'b0;
    bus.lsu_size_in = 3'd0;
    bus.io_buffer_full_in = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ram[32'h100 + 32'(j)]     = 8'(8'h11 * (j + 1));
      ref_mem[32'h100 + 32'(j)] = 8'(8'h11 * (j + 1));
    end

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Word load of a known pattern
    lsu_op(1'b0, 32'h100, 32'd0, 3'd4, 1'b1, 0);
    wait_idle();
    chk("lw_known_word", bus.lsu_data_out, 32'h4433_2211);

    // Halfword store, neighbour byte must be untouched
    lsu_op(1'b1, 32'h202, 32'hDEAD_BEEF, 3'd2, 1'b1, 0);
    wait_idle();
    check_mem(32'h202, 2);

    // Fetch and byte load together: load first, fetch starts right after
    if_op(32'h0, 3, 1'b1);
    lsu_op(1'b0, 32'h1000, 32'd0, 3'd1, 1'b1, 0);
    wait_idle();

    // Flush during a word load: no completion
    lsu_op(1'b0, 32'h100, 32'd0, 3'd4, 1'b0, 0);
    @(posedge clk); #1; bus.rollback_in = 1'b1;
    @(posedge clk); #1; bus.rollback_in = 1'b0;
    repeat (8) @(negedge clk);
    #1;

    // Flush during a word store: store still finishes
    lsu_op(1'b1, 32'h300, 32'hCAFE_F00D, 3'd4, 1'b1, 0);
    bus.rollback_in = 1'b1;
    @(posedge clk); #1; bus.rollback_in = 1'b0;
    wait_idle();
    check_mem(32'h300, 4);

    // Pending load is dropped by a flush
    lsu_op(1'b1, 32'h400, 32'h0102_0304, 3'd4, 1'b1, 0);
    lsu_op(1'b0, 32'h500, 32'd0, 3'd1, 1'b0, 0);
    bus.rollback_in = 1'b1;
    @(posedge clk); #1; bus.rollback_in = 1'b0;
    wait_idle();
    check_mem(32'h400, 4);

    // Pending store survives a flush and runs back-to-back
    lsu_op(1'b1, 32'h600, 32'h5566_7788, 3'd4, 1'b1, 0);
    lsu_op(1'b1, 32'h700, 32'h0000_00A7, 3'd1, 1'b1, 4);
    bus.rollback_in = 1'b1;
    @(posedge clk); #1; bus.rollback_in = 1'b0;
    wait_idle();
    check_mem(32'h600, 4);
    check_mem(32'h700, 1);

    // Frozen while idle: pulse is latched and served once enabled
    bus.rdy_in = 1'b0;
    lsu_op(1'b0, 32'h100, 32'd0, 3'd4, 1'b1, 3);
    @(posedge clk); #1;
    @(posedge clk); #1; bus.rdy_in = 1'b1;
    wait_idle();

    // Frozen for two edges in the middle of a store
    lsu_op(1'b1, 32'h800, 32'h1234_5678, 3'd4, 1'b1, 2);
    @(posedge clk); #1; bus.rdy_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; bus.rdy_in = 1'b1;
    wait_idle();
    check_mem(32'h800, 4);

    // Store into the I/O window while the UART buffer reports full
    bus.io_buffer_full_in = 1'b1;
    lsu_op(1'b1, 32'h0003_0000, 32'h0000_00A5, 3'd1, 1'b1, io_stall);
    chk("io_write_start", {31'd0, bus.mem_wr_out}, (io_stall == 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1; bus.io_buffer_full_in = 1'b0;
    wait_idle();
    check_mem(32'h0003_0000, 1);

    // Flush during a fetch: no completion
    if_op(32'h40, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; bus.rollback_in = 1'b1; bus.if_req_in = 1'b0;
    @(posedge clk); #1; bus.rollback_in = 1'b0;
    repeat (8) @(negedge clk);
    #1;

    // Reset between edges in the middle of a load
    lsu_op(1'b0, 32'h100, 32'd0, 3'd4, 1'b0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;

    // Random mix of fetches, loads and stores, including address wrap
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           addr = $urandom & 32'h0000_3FFF;
      sz = sizes[$urandom_range(0, 7)];
      if (kind == 0) begin
        if_op(addr, 0, 1'b1);
        wait_idle();
      end else if (kind == 1) begin
        lsu_op(1'b0, addr, 32'd0, sz, 1'b1, 0);
        wait_idle();
      end else begin
        lsu_op(1'b1, addr, $urandom, sz, 1'b1, 0);
        wait_idle();
        check_mem(addr, size_bytes(sz));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk_in  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-003 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-004 rollback_in  input  1  pipeline flush from ROB.
REQ-005 if_req_in  input  1  fetch request, level, held until if_ok_out or rollback.
REQ-006 if_addr_in  input  32  fetch byte address; always a 4-byte read.
REQ-007 if_ok_out  output  1  one-cycle pulse, if_data_out valid.
REQ-008 if_data_out  output  32  fetched word, little-endian.
REQ-009 lsu_en_in  input  1  LSU request, single-cycle pulse.
REQ-010 lsu_addr_in  input  32  LSU byte address.
REQ-011 lsu_data_in  input  32  store data, low N bytes used.
REQ-012 lsu_rw_in  input  1  0 = read, 1 = write.
REQ-013 lsu_size_in  input  3  byte count N, legal values 1, 2, 4.
REQ-014 lsu_ok_out  output  1  one-cycle pulse, access complete.
REQ-015 lsu_data_out  output  32  load data, bytes above N zero.
REQ-016 mem_a_out  output  32  RAM byte address.
REQ-017 mem_dout_out  output  8  RAM write byte.
REQ-018 mem_wr_out  output  1  RAM write strobe, 1 = write.
REQ-019 mem_din_in  input  8  RAM read byte; byte addressed in cycle c appears in cycle c+1.
REQ-020 io_buffer_full_in  input  1  UART output buffer full.

Function
REQ-021 SHALL implement states IDLE, READ, WRITE; at most one access in flight; all outputs registered.
REQ-022 SHALL latch an lsu_en_in pulse into a one-entry pending slot; the pending slot persists until the request is started.
REQ-023 In IDLE, SHALL start the pending LSU request when present, otherwise if_req_in; the LSU request has priority.
REQ-024 Read of N bytes accepted at edge E0: mem_a_out = addr+j in cycle j+1 for j = 0..N-1; byte j sampled at edge E(j+2); ok pulse in the cycle after E(N+1).
REQ-025 Write of N bytes accepted at E0: mem_a_out = addr+j, mem_dout_out = data[8j+7:8j], mem_wr_out = 1 in cycle j+1; ok pulse in the cycle after E(N); mem_wr_out = 0 in that cycle.
REQ-026 SHALL hold mem_wr_out = 0 in IDLE and READ.
REQ-027 The ok cycle is IDLE; a new request SHALL be accepted at the edge ending the ok cycle, giving back-to-back operation.
REQ-028 Address arithmetic SHALL be 32-bit modulo 2^32; wrap 0xFFFFFFFF -> 0x0 is permitted.
REQ-029 rollback_in high at an edge SHALL abort any in-flight read (IF or LSU) to IDLE with no ok pulse, and SHALL drop a pending LSU read.
REQ-030 Under rollback, an in-flight write SHALL complete normally and a pending write SHALL be kept.
REQ-031 A rollback coinciding with a read's final sampling edge SHALL suppress that read's ok pulse.
REQ-032 With rdy_in low, state, counters, and outputs SHALL hold, and new requests SHALL be ignored except that the lsu_en_in latch still captures.
REQ-033 lsu_size_in values other than 1, 2, 4 SHALL be treated as 4.

Reset
REQ-034 rst_n_in low SHALL immediately force IDLE, clear the pending slot, and drive all outputs to 0, independent of clk_in.
REQ-035 Reset mid-operation SHALL abandon the access with no ok pulse; a partial write is not rolled back.

Configuration
REQ-036 With IO_STALL_EN defined, a write with addr[17:16] = 2'b11 SHALL NOT start while io_buffer_full_in = 1.
REQ-037 Under the IO_STALL_EN stall, the controller SHALL wait in IDLE with no IF service, so ordering is preserved.
REQ-038 With IO_STALL_EN undefined, io_buffer_full_in SHALL be ignored; the port remains present.

Verification
REQ-039 LW 0x100, RAM 0x11,0x22,0x33,0x44 -> lsu_data_out = 0x44332211, lsu_ok_out high only in the cycle after E5.
REQ-040 SH 0x202, data 0xDEADBEEF -> 0xEF@0x202 then 0xBE@0x203 with mem_wr_out = 1, ok in the cycle after E2, 0x204 untouched.
REQ-041 if_req_in @0x0 and LB @0x1000 issued in the same cycle -> LB served first, then IF; exactly one ok each.
REQ-042 rollback_in at E2 of LW -> no lsu_ok_out, returns to IDLE; rollback_in at E1 of SW -> all 4 bytes written, ok pulses.
REQ-043 IO_STALL_EN: SB 0x30000 with io_buffer_full_in = 1 for 3 cycles -> mem_wr_out stays 0 until the cycle after full drops; undefined -> write starts immediately.
REQ-044 rst_n_in low mid-LW between edges -> all outputs 0 before the next clk_in edge, no ok after release.
